// File: rtl/mdu_seq.sv
// Multi-cycle RV32 M-extension unit: radix-2 shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are all zero.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       counter;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     divisor;
  logic [1:0]          fn;
  logic                neg_res;
  logic                rem_neg;

  // Operand decode, only consumed in IDLE
  logic            op1_sgn, op2_sgn, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0] abs1, abs2, special_res;

  always_comb begin
    op1_sgn  = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    op2_sgn  = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    neg1     = op1_sgn & operand_1[XLEN-1];
    neg2     = op2_sgn & operand_2[XLEN-1];
    abs1     = neg1 ? -operand_1 : operand_1;
    abs2     = neg2 ? -operand_2 : operand_2;
    div_zero = (operand_2 == '0);
    div_ovf  = op1_sgn & op2_sgn & (operand_1 == {1'b1, {(XLEN-1){1'b0}}}) & (operand_2 == '1);
    if (funct3[1]) special_res = div_zero ? operand_1 : '0;
    else           special_res = div_zero ? '1 : operand_1;
  end

  // One multiply step and its final-result view
  logic [2*XLEN-1:0] acc_nx, mcand_nx, prod;
  logic [XLEN-1:0]   mplier_nx, mul_res;
  logic              mul_last;

  always_comb begin
    acc_nx    = acc + (mplier[0] ? mcand : '0);
    mcand_nx  = mcand << 1;
    mplier_nx = mplier >> 1;
    prod      = neg_res ? -acc_nx : acc_nx;
    mul_res   = (fn == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_EARLY_OUT_EN
    mul_last  = (mplier_nx == '0);
`else
    mul_last  = (counter == '0);
`endif
  end

  // One restoring-divide step; rem[XLEN-1] set means the shifted value exceeds any divisor
  logic [XLEN-1:0] rem_lo, rem_nx, quo_nx, q_fin, r_fin, div_res;
  logic            ge;

  always_comb begin
    rem_lo  = {rem[XLEN-2:0], quo[XLEN-1]};
    ge      = rem[XLEN-1] | (rem_lo >= divisor);
    rem_nx  = ge ? rem_lo - divisor : rem_lo;
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fin   = neg_res ? -quo_nx : quo_nx;
    r_fin   = rem_neg ? -rem_nx : rem_nx;
    div_res = fn[1] ? r_fin : q_fin;
  end

  assign stall = start & ~done & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      fn      <= '0;
      neg_res <= 1'b0;
      rem_neg <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            counter <= CW'(XLEN-1);
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, abs1};
            mplier  <= abs2;
            quo     <= abs1;
            rem     <= '0;
            divisor <= abs2;
            fn      <= funct3[1:0];
            neg_res <= neg1 ^ neg2;
            rem_neg <= neg1;
            if (!funct3[2]) begin
              state <= MUL;
            end else if (div_zero | div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= DIV;
            end
          end
          MUL: begin
            acc     <= acc_nx;
            mcand   <= mcand_nx;
            mplier  <= mplier_nx;
            counter <= counter - 1'b1;
            if (mul_last) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= mul_res;
            end
          end
          DIV: begin
            rem     <= rem_nx;
            quo     <= quo_nx;
            counter <= counter - 1'b1;
            if (counter == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= div_res;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized bench for mdu_seq against a plain-arithmetic reference of the M-extension ops.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_1, operand_2;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_res;
  logic [31:0] held = '0;
  int          ref_lat;
  int          op_cyc;
  bit          op_active = 1'b0;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    bit          ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int          k;
    if (f3[2])
      return ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    m = (f3 == 3'd1 && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MDU_EARLY_OUT_EN
    return k + 1;
`else
    return (k > 0) ? 33 : 33;
`endif
  endfunction

  // Per-cycle comparison against the model's expected timeline
  always @(negedge clk) begin
    logic exp_done;
    exp_done = op_active && (op_cyc == ref_lat);
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("stall", {31'd0, stall}, {31'd0, start & ~exp_done & ~flush});
    if (exp_done) begin
      chk($sformatf("result f3=%0d %h,%h", funct3, operand_1, operand_2), result, ref_res);
      held = ref_res;
      op_active = 1'b0;
    end else begin
      chk("result_hold", result, held);
    end
    if (op_active) op_cyc++;
  end

  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3; operand_1 = a; operand_2 = b; start = 1'b1;
    ref_res = model(f3, a, b);
    ref_lat = lat_model(f3, a, b);
    op_cyc = 0;
    op_active = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    launch(f3, a, b);
    for (int i = 0; i < 80 && op_active; i++) @(posedge clk);
    if (op_active) begin
      checks++; errors++;
      $display("FAIL timeout f3=%0d no done within budget", f3);
      op_active = 1'b0;
    end
    #1;
  endtask

  task automatic lit(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    chk(name, model(f3, a, b), exp);
    do_op(f3, a, b);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; operand_1 = '0; operand_2 = '0;
    #3;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    lit("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    chk("lat_mul", ref_lat, lat_model(3'd0, 32'd7, 32'hFFFF_FFFD));
    idle(1);
    lit("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    lit("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    lit("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    lit("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    lit("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    lit("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    chk("lat_div", ref_lat, 33);
    lit("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    lit("div_zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    chk("lat_div0", ref_lat, 1);
    lit("remu_zero", 3'd7, 32'd5, 32'd0, 32'd5);
    lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    lit("mul_5x3", 3'd0, 32'd5, 32'd3, 32'd15);
`ifdef MDU_EARLY_OUT_EN
    chk("lat_5x3", ref_lat, 3);
`else
    chk("lat_5x3", ref_lat, 33);
`endif
    lit("mul_5x0", 3'd0, 32'd5, 32'd0, 32'd0);
`ifdef MDU_EARLY_OUT_EN
    chk("lat_5x0", ref_lat, 2);
`else
    chk("lat_5x0", ref_lat, 33);
`endif
    idle(2);

    // Flush in cycle 10 of a divide: no done, result keeps its old value
    launch(3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    op_active = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;
    idle(40);
    do_op(3'd5, 32'd1000, 32'd3);
    idle(1);

    // Reset in cycle 20 of a multiply
    launch(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0; op_active = 1'b0; held = '0;
    #1;
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 60; n++) begin
      do_op(3'($urandom_range(0, 7)), rnd_op(), rnd_op());
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
